// File: rtl/branch_pht.sv
// branch_pht -- pattern history table of saturating counters for branch
// direction prediction.
//
// A lookup indexes the table with lookup_pc[INDEX_W+1:2] and returns a
// combinational prediction. A resolved conditional branch trains the entry
// it was predicted from (upd_idx) and reports a registered mispredict pulse
// and a saturating misprediction count.
//
// Optional feature: define BRANCH_PHT_GSHARE_EN to build an INDEX_W-bit
// global history register. The lookup index then becomes base index XOR
// history. History shifts in act_taken on every update.
//
// Ports:
//   clk          in   clock, all state changes on rising edge
//   rstn_h       in   asynchronous active-low reset
//   lookup_pc    in   32-bit PC being predicted
//   branch_occr  in   00 not branch, 01 unconditional, 1x conditional
//   branch_taken out  combinational prediction
//   pred_idx     out  table index used by this lookup
//   upd_valid    in   resolved conditional branch this cycle
//   upd_idx      in   pred_idx captured at lookup of the resolving branch
//   act_taken    in   resolved direction
//   pred_taken   in   prediction originally issued for that branch
//   mispredict   out  registered one-cycle misprediction pulse
//   miss_cnt     out  registered saturating misprediction count
module branch_pht #(
  parameter int INDEX_W = 4,
  parameter int CTR_W   = 2,
  parameter int MISS_W  = 16
) (
  input  logic               clk,
  input  logic               rstn_h,
  input  logic [31:0]        lookup_pc,
  input  logic [1:0]         branch_occr,
  output logic               branch_taken,
  output logic [INDEX_W-1:0] pred_idx,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic               act_taken,
  input  logic               pred_taken,
  output logic               mispredict,
  output logic [MISS_W-1:0]  miss_cnt
);

  localparam int DEPTH = 1 << INDEX_W;

  localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0]  CTR_ONE  = CTR_W'(1);
  // Weakly not-taken: one below the taken threshold.
  localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  function automatic logic [CTR_W-1:0] ctr_sat_step(
    input logic [CTR_W-1:0] ctr,
    input logic             up
  );
    logic [CTR_W-1:0] res;
    res = ctr;
    if (up) begin
      if (ctr != CTR_MAX) res = ctr + CTR_ONE;
    end else begin
      if (ctr != CTR_ZERO) res = ctr - CTR_ONE;
    end
    return res;
  endfunction

  function automatic logic [MISS_W-1:0] miss_sat_inc(
    input logic [MISS_W-1:0] cnt
  );
    return (cnt == MISS_MAX) ? cnt : cnt + MISS_ONE;
  endfunction

  logic [CTR_W-1:0]   pht_q [DEPTH];
  logic [INDEX_W-1:0] base_idx;
  logic               miss_now;
  logic               mispredict_p1;
  logic [MISS_W-1:0]  miss_cnt_p1;

  // Only the word-aligned PC bits above bit 1 feed the index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:INDEX_W+2], lookup_pc[1:0]};

  assign base_idx = lookup_pc[INDEX_W+1:2];
  assign miss_now = upd_valid & (act_taken ^ pred_taken);

`ifdef BRANCH_PHT_GSHARE_EN
  logic [INDEX_W-1:0] hist_q;

  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      hist_q <= '0;
    end else if (upd_valid) begin
      hist_q <= {hist_q[INDEX_W-2:0], act_taken};
    end
  end

  assign pred_idx = base_idx ^ hist_q;
`else
  assign pred_idx = base_idx;
`endif

  // Lookup: reads current table state, so a same-cycle update to the
  // same entry only shows up on the following cycle.
  always_comb begin
    branch_taken = 1'b0;
    case (branch_occr)
      2'b00:   branch_taken = 1'b0;
      2'b01:   branch_taken = 1'b1;
      default: branch_taken = pht_q[pred_idx][CTR_W-1];
    endcase
  end

  // Update stage: train one entry, register the statistics.
  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht_q[i] <= CTR_INIT;
      end
    end else if (upd_valid) begin
      pht_q[upd_idx] <= ctr_sat_step(pht_q[upd_idx], act_taken);
    end
  end

  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      mispredict_p1 <= 1'b0;
      miss_cnt_p1   <= '0;
    end else begin
      mispredict_p1 <= miss_now;
      if (miss_now) begin
        miss_cnt_p1 <= miss_sat_inc(miss_cnt_p1);
      end
    end
  end

  assign mispredict = mispredict_p1;
  assign miss_cnt   = miss_cnt_p1;

endmodule

// File: doc/branch_pht.md
BRANCH_PHT -- requirements
Module: branch_pht

Interface
REQ-001 Parameter INDEX_W, default 4: pattern-table index width; table depth is 2^INDEX_W entries; legal range 2..10.
REQ-002 Parameter CTR_W, default 2: saturating-counter width per entry; legal range 1..4.
REQ-003 Parameter MISS_W, default 16: misprediction-counter width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rstn_h  input  1  asynchronous, active-low reset.
REQ-006 lookup_pc  input  32  PC of the instruction being predicted.
REQ-007 branch_occr  input  2  00 not a branch, 01 unconditional, 10/11 conditional.
REQ-008 branch_taken  output  1  prediction for lookup_pc, combinational.
REQ-009 pred_idx  output  INDEX_W  table index used for this lookup; the pipeline carries it to the update port.
REQ-010 upd_valid  input  1  resolved conditional branch this cycle.
REQ-011 upd_idx  input  INDEX_W  pred_idx captured at lookup of the resolving branch.
REQ-012 act_taken  input  1  resolved direction.
REQ-013 pred_taken  input  1  prediction originally issued for the resolving branch.
REQ-014 mispredict  output  1  registered; high for one cycle after an update whose act_taken differs from pred_taken.
REQ-015 miss_cnt  output  MISS_W  registered saturating count of mispredictions.

Function
REQ-016 Base index = lookup_pc[INDEX_W+1:2].
REQ-017 branch_occr 00 -> branch_taken 0; 01 -> 1; 1x -> MSB of counter at pred_idx.
REQ-018 Table read is combinational from current state; a same-cycle update to the same index is not visible until the next cycle.
REQ-019 On upd_valid with act_taken 1, the counter at upd_idx increments, saturating at 2^CTR_W-1.
REQ-020 On upd_valid with act_taken 0, the counter at upd_idx decrements, saturating at 0.
REQ-021 With upd_valid 0, no table entry, history register or statistic changes; mispredict is 0 the next cycle.
REQ-022 mispredict is registered (upd_valid & (act_taken ^ pred_taken)), one-cycle latency.
REQ-023 miss_cnt increments on every mispredicting update and holds at 2^MISS_W-1 without wrapping.
REQ-024 Only the entry at upd_idx changes; all other entries hold.
REQ-025 Counter values outside 0..2^CTR_W-1 are unreachable.

Reset
REQ-026 On rstn_h low, asynchronously: every counter becomes 2^(CTR_W-1)-1 (weakly not-taken; 1 for CTR_W=2, 0 for CTR_W=1); mispredict 0; miss_cnt 0; history register 0.
REQ-027 An update coinciding with reset assertion is discarded; normal operation resumes on the first rising clk edge with rstn_h high.

Configuration
REQ-028 Macro BRANCH_PHT_GSHARE_EN, when defined: INDEX_W-bit global history register; pred_idx = base index XOR history; on each upd_valid the history shifts left by one with act_taken entering at bit 0.
REQ-029 Macro undefined: no history register is built; pred_idx = base index; all other behaviour is identical.

Verification
REQ-030 Reset, then branch_occr=10 with any lookup_pc -> branch_taken 0; branch_occr=01 -> 1; 00 -> 0.
REQ-031 Two updates idx 3, act_taken 1, pred_taken 0 -> lookup pc 0x0C predicts 1 from the cycle after the first update; mispredict pulses twice; miss_cnt=2.
REQ-032 Five taken updates to idx 5, then one not-taken -> counter 3 then 2; prediction stays 1; saturation verified at 3 and 0.
REQ-033 Lookup pc 0x14 with same-cycle update idx 5 taken -> branch_taken reflects the old counter that cycle and the new value the next cycle.
REQ-034 MISS_W=2, four mispredicting updates -> miss_cnt 1,2,3,3.
REQ-035 With BRANCH_PHT_GSHARE_EN, updates act_taken 1,1 after reset, then lookup_pc 0x04 -> pred_idx = 1 XOR 3 = 2; rstn_h pulse mid-sequence -> history and table back to reset values.
